sound_effect_player: RTL and testbench
======================================

# sound_effect_player

Audio back end of the snake game. Consumes the one-cycle sound event pulses issued by the game logic controller (eat food, game over, game start) and plays a short fixed note sequence for each as a 1-bit square wave for the board buzzer/PWM pin. It arbitrates overlapping events by priority and reports whether a sequence is playing.

## Interface
- `M`, default 2: width of the sound event code; must equal the controller's `M`.
- `NOTE_TICKS`, default 5_000_000: duration of each note in `clk` cycles (50 ms at 100 MHz); must be at least 2.
- `HALF_LOW`, default 113_636: half-period in cycles of the low tone (440 Hz at 100 MHz); must be at least 1.
- `HALF_MID`, default 75_843: half-period of the mid tone (659 Hz).
- `HALF_HIGH`, default 56_818: half-period of the high tone (880 Hz).
- `clk`, in, 1: system clock. This block has one clock only.
- `reset_global_n`, in, 1: reset, asynchronous and active-low.
- `sound_event_code_in`, in, M: event code. 00 none, 01 EAT_FOOD, 10 GAME_OVER, 11 GAME_START.
- `sound_trigger_in`, in, 1: the code is valid in every cycle this is high.
- `sound_enable_in`, in, 1: mute control. When 0, `audio_out` is forced to 0 while sequencing continues.
- `audio_out`, out, 1: square-wave output.
- `busy_out`, out, 1: high while a sequence is playing.
- `playing_code_out`, out, M: code of the active sequence; 00 when idle.

## Operation
- Two states: IDLE and PLAY.
- Registers:
  - note index, 0..2
  - note counter, `$clog2(NOTE_TICKS)` bits
  - tone counter, sized for the largest HALF
  - phase bit
  - active code
- Sequences:
  - EAT_FOOD: HIGH, one note.
  - GAME_START: LOW, MID, HIGH.
  - GAME_OVER: HIGH, MID, LOW.
- Trigger acceptance: a trigger is accepted when `sound_trigger_in` is 1, the code is not 00, and one of these holds:
  - the block is in IDLE, or
  - the new code's priority is at least the active code's priority.
- Priority order: GAME_OVER > GAME_START > EAT_FOOD.
- An accepted trigger does the following:
  - enter PLAY
  - latch the code
  - note index = 0, note counter = 0, tone counter = 0, phase = 0
- Equal priority restarts the active sequence from note 0. Lower priority is dropped. Code 00 is always ignored.
- A trigger held high for several cycles re-triggers every cycle. The controller pulses for one cycle only.
- In PLAY, every cycle:
  - Tone counter: increments. At HALF(current note)−1 it wraps to 0 and the phase toggles.
  - Note counter: increments. At NOTE_TICKS−1 it wraps to 0, the tone counter is cleared, and phase is set to 0.
  - At that same note boundary, the note index advances. If the finished note was the last note of the sequence, the block returns to IDLE and the active code is cleared to 00.
- An accepted trigger in the same cycle as a note boundary or sequence end takes precedence; the new sequence starts.
- In IDLE all counters are held at 0 and phase is 0.
- `audio_out` = phase AND `sound_enable_in`, taken from a registered phase. `audio_out` is the only output with a combinational gate.
- Reset, asynchronous and active-low, applicable at any time including mid-sequence:
  - state = IDLE, all counters = 0, phase = 0
  - `audio_out` = 0, `busy_out` = 0, `playing_code_out` = 00
  - No sequence resumes after reset is released.

## Timing
- Trigger sampled at edge k → at edge k, `busy_out` = 1 and `playing_code_out` = code. Latency is 1 cycle from the trigger cycle.
- The first phase toggle lands at edge k+HALF. After that the phase toggles every HALF cycles, giving a period of 2·HALF.
- Note j spans edges k+j·NOTE_TICKS through k+(j+1)·NOTE_TICKS−1.
- `busy_out` stays high for exactly notes·NOTE_TICKS cycles: NOTE_TICKS for EAT_FOOD, 3·NOTE_TICKS for the other two. It then falls at edge k+notes·NOTE_TICKS.
- A note that does not end on a full half-period truncates its last half-period. Phase restarts at 0 for the next note.
- Back-to-back triggers on consecutive cycles are each accepted or dropped independently under the priority rule.
- `sound_enable_in` affects `audio_out` in the same cycle. It never affects `busy_out` or the counters.

## Test plan
Benches use NOTE_TICKS=20, HALF_LOW=5, HALF_MID=4, HALF_HIGH=3.
- **Reset:** assert `reset_global_n`=0 mid-GAME_START → `audio_out`, `busy_out`, `playing_code_out` go to 0 immediately without a clock edge and stay 0 after release.
- **EAT_FOOD:** 1-cycle trigger with code 01 at edge k → `busy_out` high for edges k..k+19, falling at k+20. `audio_out` toggles at k+3, k+6, …, k+18, then reads 0 at k+20. `playing_code_out` = 01, then 00.
- **GAME_START:** trigger with code 11 → toggle spacing is 5 cycles for edges k..k+19, 4 for k+20..k+39, 3 for k+40..k+59. Phase is 0 at k+20 and at k+40. `busy_out` falls at k+60.
- **Preemption:** EAT_FOOD playing, GAME_OVER triggered at k+7 → `playing_code_out` = 10 from k+7, first note HIGH, `busy_out` falls at k+67. A later EAT_FOOD trigger at k+30 is dropped.
- **Restart and null code:** GAME_OVER triggered again during GAME_OVER → restarts at note 0 and `busy_out` extends. Code 00 with trigger=1 while IDLE → `busy_out` stays 0.
- **Mute:** `sound_enable_in`=0 for the whole of an EAT_FOOD sequence → `audio_out` stays 0 while `busy_out` still lasts 20 cycles. Raising enable mid-note → `audio_out` matches the running phase in the same cycle.

Source files
------------

// File: rtl/sound_effect_player.sv
`default_nettype none
// ============================================================================
// Module   : sound_effect_player
// Purpose  : Audio back end of the snake game. Turns one-cycle sound event
//            pulses (eat food, game over, game start) into short fixed note
//            sequences played as a 1-bit square wave for the buzzer/PWM pin.
//            Overlapping events are arbitrated by priority
//            (GAME_OVER > GAME_START > EAT_FOOD).
// Ports    : clk                  - system clock (single clock domain)
//            reset_global_n       - asynchronous active-low reset
//            sound_event_code_in  - event code: 00 none, 01 EAT_FOOD,
//                                   10 GAME_OVER, 11 GAME_START
//            sound_trigger_in     - code is valid in every cycle this is high
//            sound_enable_in      - mute control; 0 forces audio_out low
//            audio_out            - square-wave output (phase AND enable)
//            busy_out             - high while a sequence is playing
//            playing_code_out     - code of the active sequence, 00 when idle
// Revision : 1.0 - initial release
// ============================================================================
module sound_effect_player #(
    parameter int M          = 2,
    parameter int NOTE_TICKS = 5_000_000,
    parameter int HALF_LOW   = 113_636,
    parameter int HALF_MID   = 75_843,
    parameter int HALF_HIGH  = 56_818
) (
    input  logic         clk,
    input  logic         reset_global_n,
    input  logic [M-1:0] sound_event_code_in,
    input  logic         sound_trigger_in,
    input  logic         sound_enable_in,
    output logic         audio_out,
    output logic         busy_out,
    output logic [M-1:0] playing_code_out
);

    // ------------------------------------------------------------------
    // Sizing
    // ------------------------------------------------------------------
    localparam int c_NW = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;

    localparam int c_HALF_LM  = (HALF_LOW > HALF_MID) ? HALF_LOW : HALF_MID;
    localparam int c_HALF_MAX = (c_HALF_LM > HALF_HIGH) ? c_HALF_LM : HALF_HIGH;
    localparam int c_TW       = (c_HALF_MAX > 1) ? $clog2(c_HALF_MAX) : 1;

    localparam logic [c_NW-1:0] c_NOTE_LAST = c_NW'(NOTE_TICKS - 1);
    localparam logic [c_NW-1:0] c_NOTE_ONE  = c_NW'(1);

    // Terminal tone-counter values (half-period minus one)
    localparam logic [c_TW-1:0] c_LOW_M1  = c_TW'(HALF_LOW - 1);
    localparam logic [c_TW-1:0] c_MID_M1  = c_TW'(HALF_MID - 1);
    localparam logic [c_TW-1:0] c_HIGH_M1 = c_TW'(HALF_HIGH - 1);
    localparam logic [c_TW-1:0] c_TONE_ONE = c_TW'(1);

    // Event codes
    localparam logic [M-1:0] c_CODE_NONE  = M'(0);
    localparam logic [M-1:0] c_CODE_EAT   = M'(1);
    localparam logic [M-1:0] c_CODE_OVER  = M'(2);
    localparam logic [M-1:0] c_CODE_START = M'(3);

    // FSM encoding
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PLAY = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]      r_state;
    logic [1:0]      r_note_idx;
    logic [c_NW-1:0] r_note_cnt;
    logic [c_TW-1:0] r_tone_cnt;
    logic            r_phase;
    logic            r_busy;
    logic [M-1:0]    r_active;

    logic [c_TW-1:0] w_half_m1;
    logic            w_last_note;
    logic            w_accept;

    // Priority rank; unknown codes rank 0 so they can never be accepted.
    function automatic logic [1:0] prio(input logic [M-1:0] code);
        logic [1:0] rank;
        rank = 2'd0;
        if (code == c_CODE_EAT)   rank = 2'd1;
        if (code == c_CODE_START) rank = 2'd2;
        if (code == c_CODE_OVER)  rank = 2'd3;
        return rank;
    endfunction

    // The active code is 00 in IDLE (rank 0), so one comparison covers both
    // the idle case and the equal-or-higher-priority preemption case.
    assign w_accept = sound_trigger_in
                   && (sound_event_code_in != c_CODE_NONE)
                   && (prio(sound_event_code_in) != 2'd0)
                   && (prio(sound_event_code_in) >= prio(r_active));

    // Half-period of the note currently sounding
    always_comb begin
        w_half_m1 = c_HIGH_M1;
        case (r_active)
            c_CODE_START: begin
                case (r_note_idx)
                    2'd0:    w_half_m1 = c_LOW_M1;
                    2'd1:    w_half_m1 = c_MID_M1;
                    default: w_half_m1 = c_HIGH_M1;
                endcase
            end
            c_CODE_OVER: begin
                case (r_note_idx)
                    2'd0:    w_half_m1 = c_HIGH_M1;
                    2'd1:    w_half_m1 = c_MID_M1;
                    default: w_half_m1 = c_LOW_M1;
                endcase
            end
            default: w_half_m1 = c_HIGH_M1;
        endcase
    end

    // EAT_FOOD is a single note; the other sequences have three.
    assign w_last_note = (r_active == c_CODE_EAT) ? 1'b1 : (r_note_idx == 2'd2);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_global_n) begin
        if (!reset_global_n) begin
            r_state    <= S_IDLE;
            r_note_idx <= 2'd0;
            r_note_cnt <= '0;
            r_tone_cnt <= '0;
            r_phase    <= 1'b0;
            r_busy     <= 1'b0;
            r_active   <= c_CODE_NONE;
        end else if (w_accept) begin
            // A new sequence wins over any note boundary in the same cycle.
            r_state    <= S_PLAY;
            r_busy     <= 1'b1;
            r_active   <= sound_event_code_in;
            r_note_idx <= 2'd0;
            r_note_cnt <= '0;
            r_tone_cnt <= '0;
            r_phase    <= 1'b0;
        end else begin
            case (r_state)
                S_PLAY: begin
                    if (r_note_cnt == c_NOTE_LAST) begin
                        // Note boundary: the next note restarts at phase 0,
                        // truncating any unfinished half-period.
                        r_note_cnt <= '0;
                        r_tone_cnt <= '0;
                        r_phase    <= 1'b0;
                        if (w_last_note) begin
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_active   <= c_CODE_NONE;
                            r_note_idx <= 2'd0;
                        end else begin
                            r_note_idx <= r_note_idx + 2'd1;
                        end
                    end else begin
                        r_note_cnt <= r_note_cnt + c_NOTE_ONE;
                        if (r_tone_cnt == w_half_m1) begin
                            r_tone_cnt <= '0;
                            r_phase    <= ~r_phase;
                        end else begin
                            r_tone_cnt <= r_tone_cnt + c_TONE_ONE;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_active   <= c_CODE_NONE;
                    r_note_idx <= 2'd0;
                    r_note_cnt <= '0;
                    r_tone_cnt <= '0;
                    r_phase    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: only audio_out has a gate, so mute acts within the cycle.
    // ------------------------------------------------------------------
    assign audio_out        = r_phase & sound_enable_in;
    assign busy_out         = r_busy;
    assign playing_code_out = r_active;

endmodule
`default_nettype wire

// File: tb/tb_sound_effect_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_sound_effect_player
// Purpose  : Self-checking bench for sound_effect_player. A reference model
//            describes the expected output at every edge as a function of
//            the start edge of the active sequence (note = elapsed / ticks,
//            phase = parity of elapsed-in-note / half-period).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sound_effect_player;

    localparam int M     = 2;
    localparam int NT    = 20;
    localparam int HLOW  = 5;
    localparam int HMID  = 4;
    localparam int HHIGH = 3;

    logic         clk = 1'b0;
    logic         reset_global_n = 1'b0;
    logic [M-1:0] sound_event_code_in = '0;
    logic         sound_trigger_in = 1'b0;
    logic         sound_enable_in = 1'b1;
    logic         audio_out;
    logic         busy_out;
    logic [M-1:0] playing_code_out;

    sound_effect_player #(
        .M          (M),
        .NOTE_TICKS (NT),
        .HALF_LOW   (HLOW),
        .HALF_MID   (HMID),
        .HALF_HIGH  (HHIGH)
    ) dut (
        .clk                 (clk),
        .reset_global_n      (reset_global_n),
        .sound_event_code_in (sound_event_code_in),
        .sound_trigger_in    (sound_trigger_in),
        .sound_enable_in     (sound_enable_in),
        .audio_out           (audio_out),
        .busy_out            (busy_out),
        .playing_code_out    (playing_code_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int e      = 0;  // index of the most recent rising edge

    // Reference model: which sequence was started, and at which edge
    bit         m_valid = 1'b0;
    logic [1:0] m_code  = 2'b00;
    int         m_start = 0;

    function automatic int n_notes(input logic [1:0] c);
        return (c == 2'b01) ? 1 : 3;
    endfunction

    function automatic int rank(input logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b11:   return 2;
            2'b10:   return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int half_of(input logic [1:0] c, input int j);
        int lo_mid_hi[3];
        lo_mid_hi[0] = HLOW; lo_mid_hi[1] = HMID; lo_mid_hi[2] = HHIGH;
        if (c == 2'b11) return lo_mid_hi[j];       // rising scale
        if (c == 2'b10) return lo_mid_hi[2 - j];   // falling scale
        return HHIGH;
    endfunction

    function automatic logic exp_busy(input int at);
        if (!m_valid || at < m_start) return 1'b0;
        return ((at - m_start) < n_notes(m_code) * NT);
    endfunction

    function automatic logic [1:0] exp_code(input int at);
        return exp_busy(at) ? m_code : 2'b00;
    endfunction

    function automatic logic exp_phase(input int at);
        int t, j, w;
        if (!exp_busy(at)) return 1'b0;
        t = at - m_start;
        j = t / NT;
        w = t % NT;
        return ((w / half_of(m_code, j)) % 2) == 1;
    endfunction

    task automatic check_outputs(input string tag);
        logic       eb, ea;
        logic [1:0] ec;
        eb = exp_busy(e);
        ec = exp_code(e);
        ea = exp_phase(e) & sound_enable_in;
        checks++;
        assert (busy_out === eb) else begin
            errors++;
            $error("FAIL %s busy_out edge %0d: observed %b expected %b", tag, e, busy_out, eb);
        end
        checks++;
        assert (playing_code_out === ec) else begin
            errors++;
            $error("FAIL %s playing_code_out edge %0d: observed %b expected %b", tag, e, playing_code_out, ec);
        end
        checks++;
        assert (audio_out === ea) else begin
            errors++;
            $error("FAIL %s audio_out edge %0d: observed %b expected %b", tag, e, audio_out, ea);
        end
    endtask

    // Drive inputs, clock one edge, update the model, then check.
    task automatic step(input logic t, input logic [1:0] c, input logic en, input string tag);
        logic [1:0] prev;
        sound_trigger_in    = t;
        sound_event_code_in = c;
        sound_enable_in     = en;
        @(posedge clk);
        e++;
        if (reset_global_n) begin
            prev = exp_code(e - 1);
            if (t && c != 2'b00 && rank(c) >= rank(prev)) begin
                m_valid = 1'b1;
                m_code  = c;
                m_start = e;
            end
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        int busy_len;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset_state");
        reset_global_n = 1'b1;

        // ---------------- null code while idle ----------------
        repeat (3) step(1'b1, 2'b00, 1'b1, "null_code");
        repeat (2) step(1'b0, 2'b00, 1'b1, "null_idle");

        // ---------------- EAT_FOOD ----------------
        step(1'b1, 2'b01, 1'b1, "eat");
        busy_len = busy_out ? 1 : 0;
        repeat (24) begin
            step(1'b0, 2'b00, 1'b1, "eat");
            if (busy_out) busy_len++;
        end
        checks++;
        assert (busy_len === 20) else begin
            errors++;
            $error("FAIL eat_busy_len: observed %0d expected %0d", busy_len, 20);
        end

        // ---------------- GAME_START ----------------
        step(1'b1, 2'b11, 1'b1, "start");
        repeat (64) step(1'b0, 2'b00, 1'b1, "start");

        // ---------------- preemption ----------------
        step(1'b1, 2'b01, 1'b1, "preempt");          // k
        repeat (6) step(1'b0, 2'b00, 1'b1, "preempt"); // k+1..k+6
        step(1'b1, 2'b10, 1'b1, "preempt_over");     // k+7
        repeat (22) step(1'b0, 2'b00, 1'b1, "preempt"); // k+8..k+29
        step(1'b1, 2'b01, 1'b1, "preempt_drop");     // k+30, dropped
        checks++;
        assert (playing_code_out === 2'b10) else begin
            errors++;
            $error("FAIL preempt_drop_code: observed %b expected %b", playing_code_out, 2'b10);
        end
        repeat (40) step(1'b0, 2'b00, 1'b1, "preempt");

        // ---------------- restart on equal priority ----------------
        step(1'b1, 2'b10, 1'b1, "restart");
        repeat (30) step(1'b0, 2'b00, 1'b1, "restart");
        step(1'b1, 2'b10, 1'b1, "restart_again");
        repeat (64) step(1'b0, 2'b00, 1'b1, "restart");

        // ---------------- mute ----------------
        step(1'b1, 2'b01, 1'b0, "mute");
        repeat (22) step(1'b0, 2'b00, 1'b0, "mute");
        step(1'b1, 2'b11, 1'b0, "unmute");
        repeat (7) step(1'b0, 2'b00, 1'b0, "unmute");
        sound_enable_in = 1'b1;                       // mid-cycle, no edge
        #2;
        check_outputs("unmute_same_cycle");
        repeat (60) step(1'b0, 2'b00, 1'b1, "unmute");

        // ---------------- asynchronous reset mid-sequence ----------------
        step(1'b1, 2'b11, 1'b1, "rst_mid");
        repeat (25) step(1'b0, 2'b00, 1'b1, "rst_mid");
        #1;
        reset_global_n = 1'b0;
        m_valid = 1'b0;
        #1;
        check_outputs("rst_async");
        repeat (2) step(1'b1, 2'b11, 1'b1, "rst_held");
        reset_global_n = 1'b1;
        repeat (10) step(1'b0, 2'b00, 1'b1, "rst_release");

        // ---------------- randomized ----------------
        repeat (3000) begin
            logic       rt;
            logic [1:0] rc;
            logic       ren;
            rt  = ($urandom_range(0, 11) == 0);
            rc  = 2'($urandom_range(0, 3));
            ren = ($urandom_range(0, 3) != 0);
            step(rt, rc, ren, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
